// File: rtl/mult_div_unit_pkg.sv
// Shared constants for the multiply/divide unit: data width, op encodings,
// FSM state encoding and small op-decoding helpers.
package mult_div_unit_pkg;

  localparam int SIZE = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } stateType;

  function automatic logic isSignedOp(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic isDivOp(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Execute-stage handshake and HI/LO access bundle between control and the
// multiply/divide unit.
interface mult_div_unit_if
  import mult_div_unit_pkg::*;
#(
  parameter int DATA_WIDTH = SIZE
);
  logic                  start;
  logic [1:0]            op;
  logic [DATA_WIDTH-1:0] operandA;
  logic [DATA_WIDTH-1:0] operandB;
  logic                  hiWrite;
  logic                  loWrite;
  logic [DATA_WIDTH-1:0] writeData;
  logic                  busy;
  logic                  done;
  logic                  divByZero;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;

  modport master (
    output start, op, operandA, operandB, hiWrite, loWrite, writeData,
    input  busy, done, divByZero, hi, lo
  );

  modport slave (
    input  start, op, operandA, operandB, hiWrite, loWrite, writeData,
    output busy, done, divByZero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract the divisor, keep the difference only when it did not borrow.
module div_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] remIn,
  input  logic                  dividendBit,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] remOut,
  output logic                  quotientBit
);
  logic [DATA_WIDTH:0] shifted;
  logic [DATA_WIDTH:0] trial;

  assign shifted     = {remIn, dividendBit};
  assign trial       = shifted - {1'b0, divisor};
  // remIn < divisor keeps trial within DATA_WIDTH bits, so the top bit is the borrow
  assign quotientBit = ~trial[DATA_WIDTH];
  assign remOut      = quotientBit ? trial[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit holding the HI/LO registers; works on
// operand magnitudes one bit per cycle and fixes signs in a final cycle.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int DATA_WIDTH = SIZE,
  parameter int CNT_WIDTH  = 6
) (
  input logic           clk,
  input logic           reset,
  mult_div_unit_if.slave bus
);
  stateType stateR, stateNext;

  logic [CNT_WIDTH-1:0]    countR;
  logic                    isDivR, negResR, negRemR, divZeroR;
  logic [DATA_WIDTH-1:0]   magBR, accHiR, accLoR, hiR, loR;
  logic                    busyR, doneR, divByZeroR;

  logic                    negA, negB;
  logic [DATA_WIDTH-1:0]   magA, magB;
  logic [DATA_WIDTH:0]     mulSum;
  logic [DATA_WIDTH-1:0]   divRem;
  logic                    qBit;
  logic [2*DATA_WIDTH-1:0] prodFix;
  logic [DATA_WIDTH-1:0]   fixHi, fixLo;

  // Operand sign flags and magnitudes for the op presented at start
  always_comb begin
    negA = isSignedOp(bus.op) & bus.operandA[DATA_WIDTH-1];
    negB = isSignedOp(bus.op) & bus.operandB[DATA_WIDTH-1];
    magA = negA ? -bus.operandA : bus.operandA;
    magB = negB ? -bus.operandB : bus.operandB;
  end

  assign mulSum = {1'b0, accHiR} + {1'b0, (accLoR[0] ? magBR : {DATA_WIDTH{1'b0}})};

  div_step #(.DATA_WIDTH(DATA_WIDTH)) uDivStep (
    .remIn      (accHiR),
    .dividendBit(accLoR[DATA_WIDTH-1]),
    .divisor    (magBR),
    .remOut     (divRem),
    .quotientBit(qBit)
  );

  // Sign correction of the unsigned result held in the accumulators
  always_comb begin
    prodFix = negResR ? -{accHiR, accLoR} : {accHiR, accLoR};
    if (isDivR) begin
      fixHi = negRemR ? -accHiR : accHiR;
      fixLo = negResR ? -accLoR : accLoR;
    end else begin
      fixHi = prodFix[2*DATA_WIDTH-1:DATA_WIDTH];
      fixLo = prodFix[DATA_WIDTH-1:0];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      stateR <= S_IDLE;
    end else begin
      stateR <= stateNext;
    end
  end

  // Next-state logic
  always_comb begin
    stateNext = stateR;
    case (stateR)
      S_IDLE:  stateNext = bus.start ? S_CALC : S_IDLE;
      S_CALC:  stateNext = (countR == {CNT_WIDTH{1'b0}}) ? S_FIX : S_CALC;
      S_FIX:   stateNext = S_DONE;
      S_DONE:  stateNext = S_IDLE;
      default: stateNext = S_IDLE;
    endcase
  end

  // Operand capture, iteration datapath and architectural HI/LO
  always_ff @(posedge clk) begin
    if (reset) begin
      countR   <= {CNT_WIDTH{1'b0}};
      isDivR   <= 1'b0;
      negResR  <= 1'b0;
      negRemR  <= 1'b0;
      divZeroR <= 1'b0;
      magBR    <= {DATA_WIDTH{1'b0}};
      accHiR   <= {DATA_WIDTH{1'b0}};
      accLoR   <= {DATA_WIDTH{1'b0}};
      hiR      <= {DATA_WIDTH{1'b0}};
      loR      <= {DATA_WIDTH{1'b0}};
    end else begin
      case (stateR)
        S_IDLE: begin
          if (bus.start) begin
            countR   <= CNT_WIDTH'(DATA_WIDTH - 1);
            isDivR   <= isDivOp(bus.op);
            negResR  <= negA ^ negB;
            negRemR  <= negA;
            divZeroR <= isDivOp(bus.op) && (bus.operandB == {DATA_WIDTH{1'b0}});
            magBR    <= magB;
            accHiR   <= {DATA_WIDTH{1'b0}};
            accLoR   <= magA;
          end else begin
            if (bus.hiWrite) hiR <= bus.writeData;
            if (bus.loWrite) loR <= bus.writeData;
          end
        end
        S_CALC: begin
          countR <= countR - CNT_WIDTH'(1);
          if (isDivR) begin
            accHiR <= divRem;
            accLoR <= {accLoR[DATA_WIDTH-2:0], qBit};
          end else begin
            accHiR <= mulSum[DATA_WIDTH:1];
            accLoR <= {mulSum[0], accLoR[DATA_WIDTH-1:1]};
          end
        end
        S_FIX: begin
          if (!divZeroR) begin
            hiR <= fixHi;
            loR <= fixLo;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered status outputs decoded from the upcoming state
  always_ff @(posedge clk) begin
    if (reset) begin
      busyR      <= 1'b0;
      doneR      <= 1'b0;
      divByZeroR <= 1'b0;
    end else begin
      busyR      <= (stateNext == S_CALC) || (stateNext == S_FIX);
      doneR      <= (stateNext == S_DONE);
      divByZeroR <= (stateNext == S_DONE) && divZeroR;
    end
  end

  assign bus.busy      = busyR;
  assign bus.done      = doneR;
  assign bus.divByZero = divByZeroR;
  assign bus.hi        = hiR;
  assign bus.lo        = loR;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, hand-written
// handshake corner cases, and random ops against an arithmetic reference model.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int DW  = 32;
  localparam int LAT = DW + 2;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   strayDz = 0;

  always #5 clk = ~clk;

  mult_div_unit_if #(.DATA_WIDTH(DW)) bus ();

  mult_div_unit #(.DATA_WIDTH(DW), .CNT_WIDTH(6)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always @(negedge clk) begin
    if (bus.divByZero && !bus.done) strayDz++;
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
    logic        expDz;
  } vecT;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic on full-width integers
  task automatic refOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       inout logic [31:0] h, inout logic [31:0] l, output logic dz);
    longint      sa, sb;
    logic [63:0] p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    case (op)
      OP_MULT:  begin p = sa * sb; {h, l} = p; end
      OP_MULTU: begin p = {32'd0, a} * {32'd0, b}; {h, l} = p; end
      OP_DIV: begin
        if (b == 32'd0) dz = 1'b1;
        else begin q = sa / sb; r = sa % sb; l = q[31:0]; h = r[31:0]; end
      end
      default: begin
        if (b == 32'd0) dz = 1'b1;
        else begin l = a / b; h = a % b; end
      end
    endcase
  endtask

  // Launch one op and wait (bounded) for done; latency counts the start edge as 1
  task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int busyCnt, output logic dz);
    bus.op = op; bus.operandA = a; bus.operandB = b; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1; busyCnt = 0; dz = 1'b0;
    while (!bus.done && lat < 100) begin
      if (bus.busy) busyCnt++;
      @(posedge clk); #1;
      lat++;
    end
    dz = bus.divByZero;
    check("busy_low_in_done", {31'd0, bus.busy}, 32'd0);
    @(posedge clk); #1;
    check("done_single_cycle", {31'd0, bus.done}, 32'd0);
  endtask

  vecT  vecs[10];
  int   lat, busyCnt, doneCnt;
  logic dz, mDz;
  logic [31:0] mHi, mLo, hold;

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.op = OP_MULT; bus.operandA = 32'd0; bus.operandB = 32'd0;
    bus.hiWrite = 1'b0; bus.loWrite = 1'b0; bus.writeData = 32'd0;

    vecs[0] = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vecs[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 1'b0};
    vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[4] = '{OP_DIVU,  32'h0000000A, 32'h00000000, 32'h00000000, 32'h80000000, 1'b1};
    vecs[5] = '{OP_DIVU,  32'hFFFFFFFF, 32'h0000000A, 32'h00000005, 32'h19999999, 1'b0};
    vecs[6] = '{OP_DIV,   32'hFFFFFFFF, 32'h00000000, 32'h00000005, 32'h19999999, 1'b1};
    vecs[7] = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[8] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[9] = '{OP_MULT,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1'b0};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);
    check("reset_hi", bus.hi, 32'd0);
    check("reset_lo", bus.lo, 32'd0);

    for (int i = 0; i < 10; i++) begin
      runOp(vecs[i].op, vecs[i].a, vecs[i].b, lat, busyCnt, dz);
      check($sformatf("vec%0d_latency", i), lat, LAT);
      check($sformatf("vec%0d_busy_cycles", i), busyCnt, LAT - 1);
      check($sformatf("vec%0d_hi", i), bus.hi, vecs[i].expHi);
      check($sformatf("vec%0d_lo", i), bus.lo, vecs[i].expLo);
      check($sformatf("vec%0d_divbyzero", i), {31'd0, dz}, {31'd0, vecs[i].expDz});
    end

    // MTHI / MTLO in IDLE, then both at once
    bus.hiWrite = 1'b1; bus.writeData = 32'h1234;
    @(posedge clk); #1 bus.hiWrite = 1'b0;
    check("mthi", bus.hi, 32'h1234);
    bus.loWrite = 1'b1; bus.writeData = 32'h5678;
    @(posedge clk); #1 bus.loWrite = 1'b0;
    check("mtlo", bus.lo, 32'h5678);
    check("mtlo_keeps_hi", bus.hi, 32'h1234);
    bus.hiWrite = 1'b1; bus.loWrite = 1'b1; bus.writeData = 32'hABCD;
    @(posedge clk); #1 bus.hiWrite = 1'b0; bus.loWrite = 1'b0;
    check("mthi_mtlo_hi", bus.hi, 32'hABCD);
    check("mthi_mtlo_lo", bus.lo, 32'hABCD);

    // hiWrite while busy is ignored; hi/lo hold until the result lands
    bus.op = OP_MULTU; bus.operandA = 32'd3; bus.operandB = 32'd4; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    bus.hiWrite = 1'b1; bus.writeData = 32'hDEAD;
    repeat (10) @(posedge clk);
    #1 bus.hiWrite = 1'b0;
    check("busy_hiwrite_hi_held", bus.hi, 32'hABCD);
    check("busy_lo_held", bus.lo, 32'hABCD);
    lat = 0;
    while (!bus.done && lat < 100) begin @(posedge clk); #1 lat++; end
    check("busy_hiwrite_result_hi", bus.hi, 32'd0);
    check("busy_hiwrite_result_lo", bus.lo, 32'd12);

    // start and loWrite together: op runs (div by zero), lo not written
    @(posedge clk); #1;
    bus.op = OP_DIVU; bus.operandA = 32'd100; bus.operandB = 32'd0;
    bus.start = 1'b1; bus.loWrite = 1'b1; bus.writeData = 32'hFFFF;
    @(posedge clk); #1 bus.start = 1'b0; bus.loWrite = 1'b0;
    check("start_wins_busy", {31'd0, bus.busy}, 32'd1);
    check("start_wins_lo_now", bus.lo, 32'd12);
    lat = 1;
    while (!bus.done && lat < 100) begin @(posedge clk); #1 lat++; end
    check("start_wins_latency", lat, LAT);
    check("start_wins_dz", {31'd0, bus.divByZero}, 32'd1);
    check("start_wins_lo_after", bus.lo, 32'd12);
    @(posedge clk); #1;

    // Restart pulses during CALC/FIX/DONE and operand change mid-CALC
    bus.op = OP_MULT; bus.operandA = 32'hFFFFFFFD; bus.operandB = 32'd5; bus.start = 1'b1;
    @(posedge clk); #1;
    doneCnt = 0;
    for (int i = 1; i <= 80; i++) begin
      bus.start = (i == 5) || (i == 33) || (i == 34);
      if (i == 5) begin bus.op = OP_DIVU; bus.operandB = 32'd9; end
      if (i == 10) bus.operandA = 32'd7;
      @(posedge clk); #1;
      if (bus.done) doneCnt++;
    end
    bus.start = 1'b0;
    check("restart_done_count", doneCnt, 1);
    check("restart_hi", bus.hi, 32'hFFFFFFFF);
    check("restart_lo", bus.lo, 32'hFFFFFFF1);
    check("restart_idle", {31'd0, bus.busy}, 32'd0);

    // Reset in the middle of a MULTU aborts it
    bus.op = OP_MULTU; bus.operandA = 32'hFFFFFFFF; bus.operandB = 32'hFFFFFFFF; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (19) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    check("abort_hi", bus.hi, 32'd0);
    check("abort_lo", bus.lo, 32'd0);
    doneCnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (bus.done) doneCnt++;
    end
    check("abort_no_done", doneCnt, 0);

    // Random ops and MTHI/MTLO against the reference model
    mHi = 32'd0; mLo = 32'd0;
    for (int i = 0; i < 40; i++) begin
      int sel;
      logic [1:0]  rop;
      logic [31:0] ra, rb;
      sel = $urandom_range(0, 9);
      if (sel <= 1) begin
        hold = $urandom;
        bus.writeData = hold;
        bus.hiWrite = (sel == 0); bus.loWrite = (sel == 1);
        @(posedge clk); #1 bus.hiWrite = 1'b0; bus.loWrite = 1'b0;
        if (sel == 0) mHi = hold; else mLo = hold;
        check($sformatf("rnd%0d_mt_hi", i), bus.hi, mHi);
        check($sformatf("rnd%0d_mt_lo", i), bus.lo, mLo);
      end else begin
        rop = 2'($urandom_range(0, 3));
        ra  = $urandom;
        rb  = ($urandom_range(0, 7) == 0) ? 32'd0 :
              ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 1000)) : 32'($urandom);
        if ($urandom_range(0, 5) == 0) ra = 32'h80000000;
        refOp(rop, ra, rb, mHi, mLo, mDz);
        runOp(rop, ra, rb, lat, busyCnt, dz);
        check($sformatf("rnd%0d_latency", i), lat, LAT);
        check($sformatf("rnd%0d_hi", i), bus.hi, mHi);
        check($sformatf("rnd%0d_lo", i), bus.lo, mLo);
        check($sformatf("rnd%0d_dz", i), {31'd0, dz}, {31'd0, mDz});
      end
    end

    check("divbyzero_only_with_done", strayDz, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle integer multiply/divide unit. It consumes the two register-file read ports (rs → operandA, rt → operandB) in the execute stage.
- It holds the architectural HI/LO registers.
- MFHI/MFLO results go back through the writeback mux to the register file's write-data input.
- The start/busy/done handshake lets control stall dependent instructions.

Parameters:
- DATA_WIDTH, default 32 (`SIZE): operand, HI and LO width.
- CNT_WIDTH, default 6: iteration counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- start  in  1  launch operation; sampled only in IDLE.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- operandA  in  DATA_WIDTH  rs value (multiplicand/dividend).
- operandB  in  DATA_WIDTH  rt value (multiplier/divisor).
- hiWrite  in  1  MTHI strobe.
- loWrite  in  1  MTLO strobe.
- writeData  in  DATA_WIDTH  MTHI/MTLO data.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- divByZero  out  1  valid only with done; divisor was 0.
- hi  out  DATA_WIDTH  HI register.
- lo  out  DATA_WIDTH  LO register.

Behaviour:
- Clocking: one clock; reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset: state=IDLE; hi=lo=0; busy=done=divByZero=0. Reset mid-operation aborts it; no HI/LO update.
- FSM states:
  - IDLE: start=1 → capture op, operand magnitudes and sign flags; counter=DATA_WIDTH-1; go to CALC.
  - CALC: one bit per cycle for DATA_WIDTH cycles. Multiply is shift-add. Divide is restoring (shift remainder, trial subtract, quotient bit). Counter reaching 0 → FIX.
  - FIX: apply sign correction. Load HI/LO, except on divide-by-zero, where HI/LO are unchanged. Go to DONE.
  - DONE: done=1 for this cycle only; go to IDLE. A start seen in DONE is ignored.
- Latency: start sampled at edge k → busy=1 from cycle k+1 through k+DATA_WIDTH+1. HI/LO are new and done=1 in cycle k+DATA_WIDTH+2 (34 cycles at 32 bits). This latency is fixed for all ops, including divide-by-zero. busy=0 in DONE and IDLE.
- Results:
  - MULT/MULTU: {HI,LO} = full 2·DATA_WIDTH product. Signed: magnitudes multiplied; product negated if signs differ.
  - DIV/DIVU: LO = quotient, HI = remainder. Signed: quotient truncates toward zero, remainder takes the dividend's sign. Most-negative / -1 → LO=0x80000000, HI=0 (no trap).
  - Divide by zero: HI/LO unchanged; divByZero=1 with done; divByZero=0 at all other times.
- start while busy or in DONE: ignored, no queuing.
- hiWrite/loWrite:
  - Take effect at the next edge, in IDLE only; ignored while busy.
  - If start=1 in the same cycle, start wins and the writes are discarded.
  - hiWrite and loWrite together: both registers written with writeData.
- operandA/operandB/op: only sampled at start; changes during CALC have no effect.
- hi/lo outputs: hold their previous values throughout busy.

Decomposition:
- Op encodings (OP_MULT..OP_DIVU), state encodings and `SIZE go in constant.v, the shared constants file.
- One natural sub-module: div_step, the combinational single-iteration restoring-divide step (remainder, divisor in → next remainder, quotient bit out).
- The multiply step, sign handling and the FSM stay in mult_div_unit.

Test Plan:
- Reset, then MULT with A=0xFFFFFFFD (-3), B=5 → done at cycle 34 after start; HI=0xFFFFFFFF, LO=0xFFFFFFF1; busy high exactly 33 cycles.
- MULTU with A=0xFFFFFFFF, B=2 → HI=0x00000001, LO=0xFFFFFFFE. Then DIV with A=0xFFFFFFF9 (-7), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV with A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0. Then DIVU with A=10, B=0 → done at cycle 34, divByZero=1, HI/LO unchanged.
- MTHI with writeData=0x1234 and MTLO with writeData=0x5678 in IDLE → hi=0x1234, lo=0x5678. Then hiWrite=1 during busy → hi unaffected. Then start and loWrite in the same cycle → the operation runs and lo is not written from writeData.
- Pulse start again at cycles 5 and 33 of an operation, and change operandA mid-CALC → single done, result from the original operands.
- Assert reset at cycle 20 of a MULTU → next cycle busy=0, done=0, hi=lo=0; no done pulse follows.
